axis_packet_arbiter: RTL and testbench
======================================

AXIS_PACKET_ARBITER -- requirements
Module: axis_packet_arbiter

Interface
REQ-001 The block SHALL have parameter SRC_NB, default 4, giving the number of upstream AXI-stream sources (2..16).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, giving the bit width of one data word.
REQ-003 The block SHALL have parameter ID_WIDTH, default clog2(SRC_NB), giving the width of the source-index output.
REQ-004 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port up_ready, output, SRC_NB bits: per-source ready.
REQ-007 Port up_valid, input, SRC_NB bits: per-source valid.
REQ-008 Port up_data, input, SRC_NB*DATA_WIDTH bits: source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 Port up_last, input, SRC_NB bits: per-source end-of-packet flag.
REQ-010 Port down_ready, input, 1 bit: downstream ready, typically from a deserializer.
REQ-011 Port down_valid, output reg, 1 bit: registered valid.
REQ-012 Port down_data, output reg, DATA_WIDTH bits: registered data.
REQ-013 Port down_last, output reg, 1 bit: registered end-of-packet.
REQ-014 Port down_id, output reg, ID_WIDTH bits: index of the source that produced the current down beat.
REQ-015 Port busy, output, 1 bit: high while the state is LOCK.

Function
REQ-016 The block SHALL implement a two-state FSM, IDLE and LOCK, with a grant register (ID_WIDTH bits) and a round-robin pointer ptr.
REQ-017 IDLE, any up_valid high: grant <= the first requester found scanning ptr+1, ptr+2, ... modulo SRC_NB; state <= LOCK.
REQ-018 IDLE, no up_valid high: the block SHALL hold IDLE, and every up_ready bit SHALL be 0.
REQ-019 LOCK: up_ready[grant] = down_ready | ~down_valid; all other up_ready bits SHALL be 0.
REQ-020 A beat SHALL transfer when up_valid[grant] & up_ready[grant]. On transfer: down_data <= the granted word, down_last <= up_last[grant], down_id <= grant, down_valid <= 1.
REQ-021 When down_ready is high and no beat transfers, down_valid SHALL clear to 0. While down_valid & ~down_ready, the down_* outputs SHALL hold stable.
REQ-022 A transfer with up_last[grant] high SHALL set state <= IDLE and ptr <= grant.
REQ-023 The grant SHALL be held for the whole packet regardless of other requests and of gaps in up_valid[grant]; packets are never interleaved.
REQ-024 Latency: a request seen in IDLE at cycle N SHALL be accepted no earlier than cycle N+1 and SHALL appear on down_* at cycle N+2.
REQ-025 Every packet boundary SHALL cost exactly one IDLE cycle, including back-to-back packets from the same source.
REQ-026 A sole requester SHALL be granted repeatedly; no source waits more than SRC_NB-1 packets while requesting continuously.
REQ-027 A single-beat packet (valid and last together) SHALL be accepted, and the FSM SHALL return to IDLE.
REQ-028 Requests deasserted by a non-granted source SHALL be ignored without error (AXI-stream protocol violation, no recovery required).

Reset
REQ-029 Under rst, the block SHALL set state = IDLE, grant = 0, ptr = SRC_NB-1 (so source 0 has first priority), and down_valid = down_last = 0, down_id = 0, down_data = 0.
REQ-030 rst asserted mid-packet SHALL abandon the packet: no down_last is generated, and arbitration restarts from source 0.
REQ-031 up_ready SHALL be all-zero during rst and in the first cycle after it.

Structure
REQ-032 The clog2 function SHALL live in the shared include header used by the axis blocks, guarded by an include guard.
REQ-033 The round-robin selection SHALL be one combinational sub-module, arb_rr_select, with ports req[SRC_NB], ptr and grant_idx, and a valid output.
REQ-034 The output register stage SHALL be in the top module; no FIFO is permitted.

Verification
REQ-035 SRC_NB=4, single requester src2 sending 3 beats (0xA1, 0xA2, 0xA3; last on the third) -> down_id=2 on each, down_data in order, down_last only on 0xA3, first down_valid two cycles after up_valid.
REQ-036 All 4 sources each send continuous 2-beat packets -> grant order 0,1,2,3,0, with no interleaved beats and one IDLE cycle between packets.
REQ-037 src1 is granted and src0 requests mid-packet -> src0 does not receive up_ready until after src1's last beat, then src0 is granted.
REQ-038 down_ready held low for 5 cycles mid-packet -> down_data stays stable, up_ready[grant]=0 after one buffered beat, and no beat is lost or duplicated.
REQ-039 rst pulsed during beat 2 of a 4-beat packet from src3 -> down_valid=0 the next cycle, then src0 (if requesting) is granted first.
REQ-040 Single-beat packets alternating between src0 and src1 -> each down beat has down_last=1, and down_id alternates 0,1,0,1.

Source files
------------

// File: rtl/axis_packet_arbiter_pkg.sv
// Shared definitions for the axis blocks: FSM state encoding and the clog2
// helper used to size index ports.
`ifndef AXIS_PACKET_ARBITER_PKG_SV
`define AXIS_PACKET_ARBITER_PKG_SV

package axis_packet_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  // Ceiling log2; the bound keeps 1<<i positive for any int argument.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

`endif

// File: rtl/axis_packet_arbiter_rr_select.sv
// Combinational round-robin picker: first asserted req scanning ptr+1,
// ptr+2, ... modulo SRC_NB.
module arb_rr_select #(
  parameter int SRC_NB   = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [SRC_NB-1:0]   req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [ID_WIDTH-1:0] grant_idx,
  output logic                valid
);

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    grant_idx = '0;
    valid     = 1'b0;
    for (int k = SRC_NB; k >= 1; k--) begin
      for (int j = 0; j < SRC_NB; j++) begin
        if (req[j] && (j == ((int'(ptr) + k) % SRC_NB))) begin
          grant_idx = ID_WIDTH'(j);
          valid     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-level round-robin arbiter: locks onto one source for a whole
// packet and forwards beats through a single registered output stage.
module axis_packet_arbiter
  import axis_packet_arbiter_pkg::*;
#(
  parameter int SRC_NB     = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = clog2(SRC_NB)
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [SRC_NB-1:0]            up_ready,
  input  logic [SRC_NB-1:0]            up_valid,
  input  logic [SRC_NB*DATA_WIDTH-1:0] up_data,
  input  logic [SRC_NB-1:0]            up_last,
  input  logic                         down_ready,
  output logic                         down_valid,
  output logic [DATA_WIDTH-1:0]        down_data,
  output logic                         down_last,
  output logic [ID_WIDTH-1:0]          down_id,
  output logic                         busy
);

  // Handshake: a beat moves on a rising edge where valid & ready are both
  // high on that side; the output stage holds while down_valid & ~down_ready.

  arb_state_e            state_q, state_n;
  logic [ID_WIDTH-1:0]   grant_q, grant_n;
  logic [ID_WIDTH-1:0]   ptr_q, ptr_n;
  logic [ID_WIDTH-1:0]   sel_idx;
  logic                  sel_valid;
  logic                  cur_valid;
  logic                  cur_last;
  logic [DATA_WIDTH-1:0] cur_data;
  logic                  lock_ready;
  logic                  xfer;

  arb_rr_select #(
    .SRC_NB   (SRC_NB),
    .ID_WIDTH (ID_WIDTH)
  ) u_select (
    .req       (up_valid),
    .ptr       (ptr_q),
    .grant_idx (sel_idx),
    .valid     (sel_valid)
  );

  always_comb begin
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    cur_data  = '0;
    for (int i = 0; i < SRC_NB; i++) begin
      if (grant_q == ID_WIDTH'(i)) begin
        cur_valid = up_valid[i];
        cur_last  = up_last[i];
        cur_data  = up_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // rst masks ready so a packet interrupted by reset cannot move another beat.
  assign lock_ready = (state_q == ST_LOCK) && !rst && (down_ready || !down_valid);
  assign xfer       = lock_ready && cur_valid;
  assign busy       = (state_q == ST_LOCK);

  always_comb begin
    up_ready = '0;
    for (int i = 0; i < SRC_NB; i++) begin
      up_ready[i] = lock_ready && (grant_q == ID_WIDTH'(i));
    end
  end

  always_comb begin
    state_n = state_q;
    grant_n = grant_q;
    ptr_n   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_valid) begin
          grant_n = sel_idx;
          state_n = ST_LOCK;
        end
      end
      ST_LOCK: begin
        if (xfer && cur_last) begin
          state_n = ST_IDLE;
          ptr_n   = grant_q;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= ID_WIDTH'(SRC_NB - 1);
    end else begin
      state_q <= state_n;
      grant_q <= grant_n;
      ptr_q   <= ptr_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      down_valid <= 1'b0;
      down_data  <= '0;
      down_last  <= 1'b0;
      down_id    <= '0;
    end else if (xfer) begin
      down_valid <= 1'b1;
      down_data  <= cur_data;
      down_last  <= cur_last;
      down_id    <= grant_q;
    end else if (down_ready) begin
      down_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Bench for axis_packet_arbiter: cycle table, reset-mid-packet sequence and
// randomized packets checked against a packet-level round-robin model.
module tb_axis_packet_arbiter;

  localparam int SRC_NB = 4;
  localparam int DW     = 8;
  localparam int IDW    = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [SRC_NB-1:0]    up_ready;
  logic [SRC_NB-1:0]    up_valid;
  logic [SRC_NB*DW-1:0] up_data;
  logic [SRC_NB-1:0]    up_last;
  logic                 down_ready;
  logic                 down_valid;
  logic [DW-1:0]        down_data;
  logic                 down_last;
  logic [IDW-1:0]       down_id;
  logic                 busy;

  int checks = 0;
  int errors = 0;

  axis_packet_arbiter #(
    .SRC_NB     (SRC_NB),
    .DATA_WIDTH (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .up_ready   (up_ready),
    .up_valid   (up_valid),
    .up_data    (up_data),
    .up_last    (up_last),
    .down_ready (down_ready),
    .down_valid (down_valid),
    .down_data  (down_data),
    .down_last  (down_last),
    .down_id    (down_id),
    .busy       (busy)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    up_valid   = '0;
    up_data    = '0;
    up_last    = '0;
    down_ready = 1'b1;
  endtask

  // Leaves the bench #1 after the edge that releases reset.
  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_up_ready", up_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Cycle table
  typedef struct {
    logic [3:0] vld;
    logic [7:0] dat;
    logic       lst;
    logic       drdy;
    logic       e_busy;
    logic [3:0] e_rdy;
    logic       e_dv;
    logic [7:0] e_dd;
    logic       e_dl;
    logic [1:0] e_id;
    logic       full;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic [3:0] vld, input logic [7:0] dat, input logic lst,
                              input logic drdy, input logic eb, input logic [3:0] er,
                              input logic edv, input logic [7:0] edd, input logic edl,
                              input logic [1:0] eid, input logic full);
    vec_t v;
    v.vld = vld; v.dat = dat; v.lst = lst; v.drdy = drdy;
    v.e_busy = eb; v.e_rdy = er; v.e_dv = edv; v.e_dd = edd;
    v.e_dl = edl; v.e_id = eid; v.full = full;
    return v;
  endfunction

  task automatic run_table();
    vecs[0]  = mk(4'b0100, 8'hA1, 0, 1, 0, 4'b0000, 0, 8'h00, 0, 2'd0, 1);
    vecs[1]  = mk(4'b0100, 8'hA1, 0, 1, 1, 4'b0100, 0, 8'h00, 0, 2'd0, 0);
    vecs[2]  = mk(4'b0100, 8'hA2, 0, 1, 1, 4'b0100, 1, 8'hA1, 0, 2'd2, 1);
    vecs[3]  = mk(4'b0100, 8'hA3, 1, 1, 1, 4'b0100, 1, 8'hA2, 0, 2'd2, 1);
    vecs[4]  = mk(4'b0000, 8'h00, 0, 0, 0, 4'b0000, 1, 8'hA3, 1, 2'd2, 1);
    vecs[5]  = mk(4'b0000, 8'h00, 0, 1, 0, 4'b0000, 1, 8'hA3, 1, 2'd2, 1);
    vecs[6]  = mk(4'b0011, 8'hB0, 1, 1, 0, 4'b0000, 0, 8'h00, 0, 2'd0, 0);
    vecs[7]  = mk(4'b0011, 8'hB0, 1, 1, 1, 4'b0001, 0, 8'h00, 0, 2'd0, 0);
    vecs[8]  = mk(4'b0010, 8'hB1, 1, 1, 0, 4'b0000, 1, 8'hB0, 1, 2'd0, 1);
    vecs[9]  = mk(4'b0010, 8'hB1, 1, 1, 1, 4'b0010, 0, 8'h00, 0, 2'd0, 0);
    vecs[10] = mk(4'b0000, 8'h00, 0, 1, 0, 4'b0000, 1, 8'hB1, 1, 2'd1, 1);
    vecs[11] = mk(4'b0000, 8'h00, 0, 1, 0, 4'b0000, 0, 8'h00, 0, 2'd0, 0);
    for (int r = 0; r < 12; r++) begin
      up_valid   = vecs[r].vld;
      up_data    = {SRC_NB{vecs[r].dat}};
      up_last    = vecs[r].lst ? vecs[r].vld : 4'b0000;
      down_ready = vecs[r].drdy;
      @(negedge clk);
      check($sformatf("tbl%0d_busy", r), busy, vecs[r].e_busy);
      check($sformatf("tbl%0d_up_ready", r), up_ready, vecs[r].e_rdy);
      check($sformatf("tbl%0d_down_valid", r), down_valid, vecs[r].e_dv);
      if (vecs[r].full) begin
        check($sformatf("tbl%0d_down_data", r), down_data, vecs[r].e_dd);
        check($sformatf("tbl%0d_down_last", r), down_last, vecs[r].e_dl);
        check($sformatf("tbl%0d_down_id", r), down_id, vecs[r].e_id);
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Reset during the second beat of a src3 packet, then src0 wins.
  task automatic run_reset_mid_packet();
    clear_inputs();
    up_valid[3] = 1'b1;
    up_data[3*DW +: DW] = 8'hC0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    up_data[3*DW +: DW] = 8'hC1;
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_up_ready_in_rst", up_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    up_valid = 4'b1001;
    up_data[0 +: DW] = 8'hD0;
    up_last = 4'b0001;
    @(negedge clk);
    check("rstmid_down_valid", down_valid, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_up_ready_after", up_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rstmid_grant_src0", up_ready, 4'b0001);
    @(posedge clk); #1;
    up_valid = 4'b1000;
    up_last  = 4'b0000;
    @(negedge clk);
    check("rstmid_out", {down_valid, down_id, down_last, down_data}, {1'b1, 2'd0, 1'b1, 8'hD0});
    @(posedge clk); #1;
  endtask

  // Randomized packets with a scoreboard
  logic [8:0]  src_q[SRC_NB][$];
  logic [8:0]  mq[SRC_NB][$];
  logic [10:0] exp_q[$];
  logic [1:0]  ord_q[$];

  // Packet-level model: every source with packets left requests in IDLE, so
  // the order is plain round-robin over non-empty lists starting after ptr.
  task automatic build_model();
    int ptr;
    int found;
    logic [8:0] b;
    ptr = SRC_NB - 1;
    forever begin
      found = -1;
      for (int k = 1; k <= SRC_NB; k++) begin
        if (found < 0 && mq[(ptr + k) % SRC_NB].size() > 0) found = (ptr + k) % SRC_NB;
      end
      if (found < 0) break;
      do begin
        b = mq[found].pop_front();
        exp_q.push_back({2'(found), b});
        ord_q.push_back(2'(found));
      end while (!b[8]);
      ptr = found;
    end
  endtask

  task automatic run_random();
    logic [SRC_NB-1:0] mid;
    logic [SRC_NB-1:0] fire;
    logic [8:0]  b;
    logic [10:0] e;
    int cycles;
    int np;
    int len;
    for (int s = 0; s < SRC_NB; s++) begin
      src_q[s].delete();
      np = $urandom_range(1, 4);
      for (int p = 0; p < np; p++) begin
        len = $urandom_range(1, 4);
        for (int i = 0; i < len; i++) src_q[s].push_back({(i == len - 1), 8'($urandom)});
      end
      mq[s] = src_q[s];
    end
    build_model();
    mid = '0;
    cycles = 0;
    while (exp_q.size() > 0 && cycles < 5000) begin
      for (int s = 0; s < SRC_NB; s++) begin
        if (src_q[s].size() > 0 && !(mid[s] && $urandom_range(0, 3) == 0)) begin
          up_valid[s] = 1'b1;
          up_data[s*DW +: DW] = src_q[s][0][7:0];
          up_last[s] = src_q[s][0][8];
        end else begin
          up_valid[s] = 1'b0;
          up_data[s*DW +: DW] = 8'($urandom);
          up_last[s] = 1'($urandom);
        end
      end
      down_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      if (up_ready != 0) begin
        if (ord_q.size() == 0) begin
          check("rnd_unexpected_ready", up_ready, 0);
        end else begin
          check("rnd_ready_owner", up_ready, 4'b0001 << ord_q[0]);
        end
      end
      if (down_valid && !down_ready) check("rnd_stall_ready", up_ready, 0);
      fire = up_valid & up_ready;
      if (down_valid && down_ready) begin
        if (exp_q.size() == 0) begin
          check("rnd_extra_beat", {down_id, down_last, down_data}, 0);
        end else begin
          e = exp_q.pop_front();
          check("rnd_beat", {down_id, down_last, down_data}, e);
        end
      end
      @(posedge clk); #1;
      for (int s = 0; s < SRC_NB; s++) begin
        if (fire[s]) begin
          b = src_q[s].pop_front();
          mid[s] = !b[8];
          if (ord_q.size() > 0) void'(ord_q.pop_front());
        end
      end
      cycles++;
    end
    check("rnd_drained", exp_q.size(), 0);
    check("rnd_upstream_drained", ord_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    do_reset();
    run_table();
    do_reset();
    run_reset_mid_packet();
    for (int t = 0; t < 6; t++) begin
      do_reset();
      run_random();
    end
    clear_inputs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
